psum_accum_sfu: RTL and testbench
=================================

// Module: psum_accum_sfu
// PURPOSE
//   Downstream of the MAC column array: accumulates signed partial sums from all col lanes into a DEPTH-entry register bank.
//   Partial sums come from 4-bit or 2-bit SIMD MAC operation; arithmetic is identical in both cases.
//   On command, drains the bank in address order with optional ReLU, then clears it for the next tile.
// PARAMETERS
//   psum_bw  16  width of one signed partial sum (matches MAC out)
//   col      8   number of lanes, one per array column
//   depth    16  accumulator entries per lane
//   addr_bw  4   address width, clog2(depth)
// PORTS
//   clk         in   1              rising-edge clock
//   reset       in   1              synchronous, active-high
//   in_valid    in   1              in_psum/in_addr valid
//   in_ready    out  1              block can accept input
//   in_addr     in   addr_bw        target entry
//   in_psum     in   col*psum_bw    lane k = bits [k*psum_bw +: psum_bw], signed
//   drain_start in   1              pulse: begin drain
//   relu_en     in   1              sampled with drain_start; apply ReLU on drain
//   out_valid   out  1              out_data/out_addr valid
//   out_ready   in   1              consumer accepts
//   out_addr    out  addr_bw        entry being drained
//   out_data    out  col*psum_bw    drained (optionally ReLU'd) entry, lane-packed as in_psum
//   drain_done  out  1              one-cycle pulse after last entry handshakes
//   busy        out  1              high in ACC or DRAIN
// BEHAVIOUR
//   Reset
//   - All outputs 0, except in_ready = 1.
//   - State IDLE; all occupied bits cleared; relu latch 0.
//   - Bank contents are don't-care, masked by the occupied bits.
//   States
//   - IDLE -> ACC on accepted write.
//   - IDLE/ACC -> DRAIN on drain_start.
//   - DRAIN -> IDLE on last handshake.
//   - drain_start while in DRAIN is ignored.
//   in_ready = (state != DRAIN). A write is accepted when in_valid & in_ready.
//   Accepted write, per lane:
//   - occupied[addr]=0: acc <= in_psum.
//   - occupied[addr]=1: acc <= sat(acc + in_psum), then set occupied[addr].
//   - sat: compute in psum_bw+1 bits, clamp to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
//   Simultaneous in_valid & drain_start in IDLE/ACC: the write commits first and is included in the drain.
//   Drain
//   - Cycle T drain_start: latch relu_en. At T+1, state=DRAIN, rd_ptr=0, out_valid=1.
//   - out_data is combinational from the bank at rd_ptr; out_addr = rd_ptr.
//   - Handshake = out_valid & out_ready. On handshake rd_ptr++, so full throughput is 1 entry/cycle.
//   - Without handshake, out_data/out_addr hold stable.
//   - Unoccupied entries emit 0 in every lane.
//   - ReLU: a negative lane outputs 0; otherwise the value passes unchanged.
//   - On handshake at rd_ptr = depth-1: next cycle state=IDLE, out_valid=0, drain_done=1 for 1 cycle, all occupied cleared.
//   busy = (state != IDLE).
//   Reset mid-drain aborts: occupied cleared, drain_done not pulsed.
//   Out-of-range addresses are impossible when depth = 2^addr_bw; other depth values are not supported.
// TESTING
//   1. Reset: reset 2 cycles -> out_valid=0, drain_done=0, busy=0, in_ready=1.
//   2. Accumulate: lane0 writes 5, -3, 7 to addr 2; drain relu_en=0 -> addr2 lane0=9, all other entries 0, 16 beats, drain_done once.
//   3. Saturation: lane1 addr0 writes 32000 then 1000 -> 32767; writes -32768 then -1 -> -32768.
//   4. ReLU: addr5 lane0=-4, lane1=6; drain relu_en=1 -> lane0=0, lane1=6; relu_en=0 -> lane0=-4.
//   5. Backpressure: toggle out_ready randomly -> out_data stable while stalled.
//      - Every addr 0..15 emitted exactly once, in order.
//      - in_ready=0 throughout the drain; in_valid ignored during it.
//   6. Edge cases:
//      - in_valid + drain_start in same cycle, value 3 -> value 3 appears in the drain.
//      - reset at beat 7 -> idle; the following drain outputs all zeros.

Source files
------------

// File: rtl/psum_accum_sfu.sv
// Partial-sum accumulator bank with saturating per-lane adds and an
// in-order drain with optional ReLU, cleared at the end of each tile.
module psum_accum_sfu #(
   parameter int psum_bw = 16,
   parameter int col     = 8,
   parameter int depth   = 16,
   parameter int addr_bw = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [addr_bw-1:0]       in_addr,
   input  logic [col*psum_bw-1:0]   in_psum,
   input  logic                     drain_start,
   input  logic                     relu_en,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [addr_bw-1:0]       out_addr,
   output logic [col*psum_bw-1:0]   out_data,
   output logic                     drain_done,
   output logic                     busy
);

   typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

   localparam logic [psum_bw-1:0] max_v = {1'b0, {(psum_bw-1){1'b1}}};
   localparam logic [psum_bw-1:0] min_v = {1'b1, {(psum_bw-1){1'b0}}};
   localparam logic [addr_bw-1:0] last_addr = addr_bw'(depth-1);

   state_t                 state;
   logic [col*psum_bw-1:0] bank [depth];
   logic [depth-1:0]       occupied;
   logic [addr_bw-1:0]     rd_ptr;
   logic                   relu_q;
   logic [col*psum_bw-1:0] wr_data;
   logic                   wr_en;
   logic                   hs;

   assign wr_en    = in_valid & in_ready;
   assign hs       = out_valid & out_ready;
   assign out_addr = rd_ptr;

   for (genvar k = 0; k < col; k++) begin : g_lane
      logic [psum_bw-1:0] a;
      logic [psum_bw-1:0] b;
      logic [psum_bw-1:0] r;
      logic [psum_bw:0]   s;
      logic [psum_bw-1:0] sum_sat;

      assign a = bank[in_addr][k*psum_bw +: psum_bw];
      assign b = in_psum[k*psum_bw +: psum_bw];
      assign s = {a[psum_bw-1], a} + {b[psum_bw-1], b};

      // Overflow shows as disagreement between the two top sum bits.
      always_comb begin
         sum_sat = s[psum_bw-1:0];
         if (s[psum_bw] != s[psum_bw-1])
            sum_sat = s[psum_bw] ? min_v : max_v;
      end

      assign wr_data[k*psum_bw +: psum_bw] =
         occupied[in_addr] ? sum_sat : b;

      assign r = occupied[rd_ptr] ? bank[rd_ptr][k*psum_bw +: psum_bw]
                                  : '0;
      assign out_data[k*psum_bw +: psum_bw] =
         (relu_q && r[psum_bw-1]) ? '0 : r;
   end

   // Bank contents need no reset; stale entries are masked by occupied.
   always_ff @(posedge clk) begin
      if (wr_en)
         bank[in_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         occupied   <= '0;
         relu_q     <= 1'b0;
         rd_ptr     <= '0;
         out_valid  <= 1'b0;
         drain_done <= 1'b0;
         busy       <= 1'b0;
         in_ready   <= 1'b1;
      end else begin
         drain_done <= 1'b0;
         if (wr_en)
            occupied[in_addr] <= 1'b1;
         unique case (state)
            IDLE, ACC: begin
               if (drain_start) begin
                  state     <= DRAIN;
                  rd_ptr    <= '0;
                  out_valid <= 1'b1;
                  relu_q    <= relu_en;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
               end else if (wr_en) begin
                  state <= ACC;
                  busy  <= 1'b1;
               end
            end
            DRAIN: begin
               if (hs) begin
                  if (rd_ptr == last_addr) begin
                     state      <= IDLE;
                     out_valid  <= 1'b0;
                     drain_done <= 1'b1;
                     occupied   <= '0;
                     in_ready   <= 1'b1;
                     busy       <= 1'b0;
                     rd_ptr     <= '0;
                  end else begin
                     rd_ptr <= rd_ptr + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psum_accum_sfu.sv
// Scoreboard bench for psum_accum_sfu: directed writes and drains,
// expected beats queued at drain start, monitor checks each handshake.
module tb_psum_accum_sfu;

   localparam int PW = 16;
   localparam int NC = 8;
   localparam int ND = 16;
   localparam int AW = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [AW-1:0]   in_addr;
   logic [NC*PW-1:0] in_psum;
   logic            drain_start;
   logic            relu_en;
   logic            out_valid;
   logic            out_ready;
   logic [AW-1:0]   out_addr;
   logic [NC*PW-1:0] out_data;
   logic            drain_done;
   logic            busy;

   psum_accum_sfu #(
      .psum_bw(PW), .col(NC), .depth(ND), .addr_bw(AW)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_psum(in_psum),
      .drain_start(drain_start), .relu_en(relu_en),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_data(out_data),
      .drain_done(drain_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   bit mon_en   = 1'b0;
   bit rnd_mode = 1'b0;

   logic [AW-1:0]    exp_a [$];
   logic [NC*PW-1:0] exp_d [$];

   int mdl  [ND][NC];
   bit mocc [ND];

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   // Reference: integer add then clamp to the signed 16-bit range.
   task automatic mdl_write(input int a, input int l, input int v);
      int s;
      if (!mocc[a]) begin
         for (int k = 0; k < NC; k++) mdl[a][k] = 0;
         mocc[a] = 1'b1;
      end
      s = mdl[a][l] + v;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      mdl[a][l] = s;
   endtask

   task automatic mdl_clear();
      for (int a = 0; a < ND; a++) begin
         mocc[a] = 1'b0;
         for (int k = 0; k < NC; k++) mdl[a][k] = 0;
      end
   endtask

   task automatic push_drain(input bit relu);
      logic [NC*PW-1:0] d;
      logic [AW-1:0]    aa;
      int v;
      for (int a = 0; a < ND; a++) begin
         d = '0;
         for (int k = 0; k < NC; k++) begin
            v = mocc[a] ? mdl[a][k] : 0;
            if (relu && v < 0) v = 0;
            d[k*PW +: PW] = v[PW-1:0];
         end
         aa = a[AW-1:0];
         exp_a.push_back(aa);
         exp_d.push_back(d);
      end
      mdl_clear();
   endtask

   task automatic wr1(input int a, input int l, input int v);
      in_valid = 1'b1;
      in_addr  = a[AW-1:0];
      in_psum  = '0;
      in_psum[l*PW +: PW] = v[PW-1:0];
      mdl_write(a, l, v);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_psum  = '0;
   endtask

   task automatic do_drain(input bit relu, input bit junk, input bit wv,
                           input int wa, input int wl, input int wval);
      int  d0;
      bit  seen;
      if (wv) mdl_write(wa, wl, wval);
      push_drain(relu);
      d0 = done_cnt;
      drain_start = 1'b1;
      relu_en     = relu;
      if (wv) begin
         in_valid = 1'b1;
         in_addr  = wa[AW-1:0];
         in_psum  = '0;
         in_psum[wl*PW +: PW] = wval[PW-1:0];
      end
      @(posedge clk); #1;
      drain_start = 1'b0;
      relu_en     = 1'b0;
      in_valid    = 1'b0;
      in_psum     = '0;
      chk("busy_in_drain", 128'(busy), 128'(1));
      chk("in_ready_in_drain", 128'(in_ready), 128'(0));
      if (junk) begin
         in_valid = 1'b1;
         in_addr  = 4'd3;
         in_psum  = 128'd100;
      end
      seen = 1'b0;
      for (int c = 0; c < 500 && !seen; c++) begin
         @(posedge clk); #1;
         if (drain_done) seen = 1'b1;
      end
      in_valid = 1'b0;
      in_psum  = '0;
      chk("drain_done_seen", 128'(seen), 128'(1));
      @(posedge clk); #1;
      chk("drain_done_pulse_len", 128'(drain_done), 128'(0));
      chk("drain_done_count", 128'(done_cnt - d0), 128'(1));
      chk("queue_empty", 128'(exp_a.size()), 128'(0));
      chk("busy_after_drain", 128'(busy), 128'(0));
      chk("in_ready_after_drain", 128'(in_ready), 128'(1));
      exp_a.delete();
      exp_d.delete();
   endtask

   // Consumer backpressure: changes just after each rising edge.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: samples on the falling edge, away from the active edge.
   logic             stalled = 1'b0;
   logic [AW-1:0]    held_a;
   logic [NC*PW-1:0] held_d;
   initial begin
      forever begin
         @(negedge clk);
         if (drain_done) done_cnt++;
         if (!mon_en || !out_valid) begin
            stalled = 1'b0;
         end else begin
            chk("in_ready_low_drain", 128'(in_ready), 128'(0));
            if (stalled) begin
               chk("stall_addr", 128'(out_addr), 128'(held_a));
               chk("stall_data", 128'(out_data), 128'(held_d));
            end
            if (out_ready) begin
               stalled = 1'b0;
               if (exp_a.size() == 0) begin
                  chk("unexpected_beat", 128'(1), 128'(0));
               end else begin
                  chk("beat_addr", 128'(out_addr), 128'(exp_a.pop_front()));
                  chk("beat_data", 128'(out_data), 128'(exp_d.pop_front()));
               end
            end else begin
               stalled = 1'b1;
               held_a  = out_addr;
               held_d  = out_data;
            end
         end
      end
   end

   initial begin
      int d0;
      bit found;
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_addr     = '0;
      in_psum     = '0;
      drain_start = 1'b0;
      relu_en     = 1'b0;
      mdl_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_drain_done", 128'(drain_done), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_out_addr", 128'(out_addr), 128'(0));
      chk("rst_out_data", 128'(out_data), 128'(0));
      reset  = 1'b0;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Accumulate: 5 - 3 + 7 = 9 at addr 2 lane 0
      wr1(2, 0, 5);
      chk("busy_acc", 128'(busy), 128'(1));
      wr1(2, 0, -3);
      wr1(2, 0, 7);
      do_drain(1'b0, 1'b0, 1'b0, 0, 0, 0);

      // Saturation at both ends
      wr1(0, 1, 32000);
      wr1(0, 1, 1000);
      wr1(1, 1, -32768);
      wr1(1, 1, -1);
      wr1(15, 7, -20000);
      wr1(15, 7, 20000);
      do_drain(1'b0, 1'b0, 1'b0, 0, 0, 0);

      // ReLU on, then off
      wr1(5, 0, -4);
      wr1(5, 1, 6);
      do_drain(1'b1, 1'b0, 1'b0, 0, 0, 0);
      wr1(5, 0, -4);
      wr1(5, 1, 6);
      do_drain(1'b0, 1'b0, 1'b0, 0, 0, 0);

      // Backpressure with writes attempted during the drain
      for (int a = 0; a < ND; a++) wr1(a, a % NC, a * 100 - 700);
      wr1(7, 7, -1234);
      rnd_mode = 1'b1;
      do_drain(1'b1, 1'b1, 1'b0, 0, 0, 0);
      do_drain(1'b0, 1'b1, 1'b0, 0, 0, 0);
      rnd_mode = 1'b0;

      // Write coincident with drain_start is included
      do_drain(1'b0, 1'b0, 1'b1, 4, 3, 3);

      // Reset at beat 7 aborts the drain
      wr1(9, 2, 55);
      mon_en = 1'b0;
      d0 = done_cnt;
      drain_start = 1'b1;
      @(posedge clk); #1;
      drain_start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         if (out_valid && out_addr == 4'd7) found = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      chk("abort_beat7_reached", 128'(found), 128'(1));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_out_valid", 128'(out_valid), 128'(0));
      chk("abort_busy", 128'(busy), 128'(0));
      chk("abort_in_ready", 128'(in_ready), 128'(1));
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", 128'(done_cnt - d0), 128'(0));
      mdl_clear();
      mon_en = 1'b1;
      do_drain(1'b0, 1'b0, 1'b0, 0, 0, 0);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
